// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order fetch requests, keeps a small
// instruction queue of reserved/filled slots, and hands the oldest filled
// slot to decode. A redirect flushes the queue and counts the requests still
// in flight so their late responses can be discarded.
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int            PW       = $clog2(DEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW:0]   DEPTH_C  = (CW+1)'(DEPTH);

    // Slot storage: headPtr is the oldest slot, fillPtr the oldest pending
    // slot and tailPtr the next free slot. Pending slots always sit between
    // the filled ones and the tail because responses come back in order.
    logic [31:0]    slotPc_q    [DEPTH];
    logic [31:0]    slotPc_d    [DEPTH];
    logic [31:0]    slotInstr_q [DEPTH];
    logic [31:0]    slotInstr_d [DEPTH];
    logic [DEPTH-1:0] slotFilled_q, slotFilled_d;
    logic [PW-1:0]  headPtr_q, headPtr_d;
    logic [PW-1:0]  tailPtr_q, tailPtr_d;
    logic [PW-1:0]  fillPtr_q, fillPtr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  pend_q, pend_d;
    logic [CW-1:0]  drop_q, drop_d;

    logic           accept;
    logic           pop;
    logic           rspFill;
    logic [CW-1:0]  outstanding;

    assign imem_req_addr  = {pc_cur[31:2], 2'b00};
    assign imem_req_valid = reset && !redirect &&
                            (({1'b0, count_q} + {1'b0, drop_q}) < DEPTH_C);
    assign accept         = imem_req_valid && imem_req_ready;
    assign if_valid       = (count_q != '0) && slotFilled_q[headPtr_q];
    assign if_pc          = if_valid ? slotPc_q[headPtr_q] : '0;
    assign if_instr       = if_valid ? slotInstr_q[headPtr_q] : '0;
    assign pop            = if_valid && !stall;
    assign rspFill        = imem_rsp_valid && (drop_q == '0) && (pend_q != '0);
    assign outstanding    = drop_q + pend_q;

    // Select the value loaded into the external PC register.
    always_comb begin
        pc_next = pc_cur;
        if (!reset) begin
            pc_next = RESET_PC;
        end else if (redirect) begin
            pc_next = redirect_target;
        end else if (accept) begin
            pc_next = pc_cur + 32'd4;
        end
    end

    // Next-state for the queue: flush on redirect, otherwise apply
    // response fill, head pop and tail reserve independently.
    always_comb begin
        slotPc_d     = slotPc_q;
        slotInstr_d  = slotInstr_q;
        slotFilled_d = slotFilled_q;
        headPtr_d    = headPtr_q;
        tailPtr_d    = tailPtr_q;
        fillPtr_d    = fillPtr_q;
        count_d      = count_q;
        pend_d       = pend_q;
        drop_d       = drop_q;
        if (redirect) begin
            headPtr_d    = '0;
            tailPtr_d    = '0;
            fillPtr_d    = '0;
            count_d      = '0;
            pend_d       = '0;
            slotFilled_d = '0;
            drop_d       = (imem_rsp_valid && outstanding != '0) ?
                           outstanding - CNT_ONE : outstanding;
        end else begin
            if (imem_rsp_valid && drop_q != '0) begin
                drop_d = drop_q - CNT_ONE;
            end
            if (rspFill) begin
                slotInstr_d[fillPtr_q]  = imem_rsp_data;
                slotFilled_d[fillPtr_q] = 1'b1;
                fillPtr_d               = fillPtr_q + PTR_ONE;
                pend_d                  = pend_d - CNT_ONE;
            end
            if (pop) begin
                slotFilled_d[headPtr_q] = 1'b0;
                headPtr_d               = headPtr_q + PTR_ONE;
                count_d                 = count_d - CNT_ONE;
            end
            if (accept) begin
                slotPc_d[tailPtr_q]     = pc_cur;
                slotInstr_d[tailPtr_q]  = '0;
                slotFilled_d[tailPtr_q] = 1'b0;
                tailPtr_d               = tailPtr_q + PTR_ONE;
                count_d                 = count_d + CNT_ONE;
                pend_d                  = pend_d + CNT_ONE;
            end
        end
    end

    // Queue state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            headPtr_q    <= '0;
            tailPtr_q    <= '0;
            fillPtr_q    <= '0;
            count_q      <= '0;
            pend_q       <= '0;
            drop_q       <= '0;
            slotFilled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slotPc_q[i]    <= '0;
                slotInstr_q[i] <= '0;
            end
        end else begin
            headPtr_q    <= headPtr_d;
            tailPtr_q    <= tailPtr_d;
            fillPtr_q    <= fillPtr_d;
            count_q      <= count_d;
            pend_q       <= pend_d;
            drop_q       <= drop_d;
            slotFilled_q <= slotFilled_d;
            slotPc_q     <= slotPc_d;
            slotInstr_q  <= slotInstr_d;
        end
    end

endmodule
